// File: rtl/display_scan_ctrl.sv
// Refresh scan controller for a 4-digit multiplexed 7-segment display.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_digit_data,
  input  logic        i_upd_req,
  output logic        o_upd_ack,
  output logic        o_busy,
  output logic        o_a1,
  output logic        o_a0,
  output logic [3:0]  o_nibble,
  output logic        o_blank,
  output logic        o_tick,
  output logic        o_frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic          r_pending;
  logic          r_upd_ack;
  logic          r_tick;
  logic          r_frame_done;
  logic [3:0]    r_nibble;

  logic          w_advance;
  logic          w_boundary;
  logic          w_load;
  logic [1:0]    w_next_idx;
  logic [15:0]   w_src_data;

  function automatic logic [3:0] digit_of(input logic [15:0] data, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = data[3:0];
      2'd1:    d = data[7:4];
      2'd2:    d = data[11:8];
      2'd3:    d = data[15:12];
      default: d = 4'h0;
    endcase
    return d;
  endfunction

  // Scan advance, frame boundary and shadow-load decisions for this edge.
  always_comb begin
    w_advance  = 1'b0;
    w_boundary = 1'b0;
    w_load     = 1'b0;
    w_next_idx = r_idx + 2'd1;
    w_src_data = r_shadow;
    w_advance  = i_en && (r_cnt == CNT_MAX);
    w_boundary = w_advance && (r_idx == 2'd3);
    w_load     = w_boundary && (r_pending || i_upd_req);
    // The new digit shown at a loading boundary comes straight from the input.
    if (w_load) begin
      w_src_data = i_digit_data;
    end else begin
      w_src_data = r_shadow;
    end
  end

  // Prescale counter, digit index, shadow register and handshake state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_shadow     <= 16'h0000;
      r_pending    <= 1'b0;
      r_upd_ack    <= 1'b0;
      r_tick       <= 1'b0;
      r_frame_done <= 1'b0;
      r_nibble     <= 4'h0;
    end else begin
      if (i_en) begin
        if (w_advance) begin
          r_cnt    <= '0;
          r_idx    <= w_next_idx;
          r_nibble <= digit_of(w_src_data, w_next_idx);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_load) begin
        r_shadow  <= i_digit_data;
        r_pending <= 1'b0;
      end else if (i_upd_req) begin
        r_pending <= 1'b1;
      end
      r_upd_ack    <= w_load;
      r_tick       <= w_advance;
      r_frame_done <= w_boundary;
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  logic r_blank;

  function automatic logic lz_blank(input logic [15:0] data, input logic [1:0] idx);
    logic b;
    case (idx)
      2'd3:    b = (data[15:12] == 4'h0);
      2'd2:    b = (data[15:8] == 8'h00);
      2'd1:    b = (data[15:4] == 12'h000);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Blank flag tracks the digit loaded alongside the nibble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blank <= 1'b0;
    end else if (w_advance) begin
      r_blank <= lz_blank(w_src_data, w_next_idx);
    end
  end

  assign o_blank = r_blank;
`else
  assign o_blank = 1'b0;
`endif

  assign o_upd_ack    = r_upd_ack;
  assign o_busy       = r_pending;
  assign o_a1         = r_idx[1];
  assign o_a0         = r_idx[0];
  assign o_nibble     = r_nibble;
  assign o_tick       = r_tick;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: an enabled-cycle arithmetic
// model checked every cycle, plus hand-computed literal checkpoints.
module tb_display_scan_ctrl;

  localparam int P = 4;
`ifdef DISPLAY_SCAN_LZB_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, upd_req;
  logic [15:0] digit_data;
  logic        upd_ack, busy, a1, a0, blank, tick, frame_done;
  logic [3:0]  nibble;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // model state: count of enabled edges since reset, shadow, pending
  int          e = 0;
  logic [15:0] m_shadow = 16'h0000;
  bit          m_pend = 1'b0, m_ack = 1'b0, m_tick = 1'b0, m_fd = 1'b0;

  display_scan_ctrl #(.PRESCALE(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_digit_data(digit_data),
    .i_upd_req(upd_req), .o_upd_ack(upd_ack), .o_busy(busy),
    .o_a1(a1), .o_a0(a0), .o_nibble(nibble), .o_blank(blank),
    .o_tick(tick), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int m_idx();
    return (e / P) % 4;
  endfunction

  function automatic logic [3:0] m_nib();
    return 4'((m_shadow >> (4 * m_idx())) & 16'h000F);
  endfunction

  function automatic logic m_blank();
    return LZB && (m_idx() != 0) && ((m_shadow >> (4 * m_idx())) == 16'h0000);
  endfunction

  // Model update on the same edge the DUT samples.
  always @(posedge clk) begin : model
    bit adv, bnd, ld;
    if (rst) begin
      e = 0; m_shadow = 16'h0000; m_pend = 1'b0;
      m_ack = 1'b0; m_tick = 1'b0; m_fd = 1'b0;
    end else begin
      adv = en && ((e % P) == P - 1);
      bnd = adv && (((e / P) % 4) == 3);
      ld  = bnd && (m_pend || upd_req);
      m_ack = ld; m_tick = adv; m_fd = bnd;
      if (ld) begin
        m_shadow = digit_data;
        m_pend = 1'b0;
      end else if (upd_req) begin
        m_pend = 1'b1;
      end
      if (en) e++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("idx",        16'({a1, a0}),   16'(m_idx()));
      check("nibble",     16'(nibble),     16'(m_nib()));
      check("blank",      16'(blank),      16'(m_blank()));
      check("tick",       16'(tick),       16'(m_tick));
      check("frame_done", 16'(frame_done), 16'(m_fd));
      check("upd_ack",    16'(upd_ack),    16'(m_ack));
      check("busy",       16'(busy),       16'(m_pend));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int acks;
    rst = 1'b1; en = 1'b0; upd_req = 1'b0; digit_data = 16'h0000;
    step(2);
    chk_on = 1'b1;
    check("rst_idx", 16'({a1, a0}), 16'd0);
    check("rst_nibble", 16'(nibble), 16'h0);
    check("rst_flags", 16'({tick, frame_done, upd_ack, busy, blank}), 16'h0);

    rst = 1'b0; en = 1'b1;
    step(4);                                   // e=4
    check("lit_idx1", 16'({a1, a0}), 16'd1);
    check("lit_tick1", 16'(tick), 16'd1);
    step(12);                                  // e=16
    check("lit_wrap_idx", 16'({a1, a0}), 16'd0);
    check("lit_frame_done", 16'(frame_done), 16'd1);

    step(5);                                   // e=21, mid-frame request
    digit_data = 16'h1234; upd_req = 1'b1;
    step(1);                                   // e=22
    upd_req = 1'b0;
    check("lit_busy_mid", 16'(busy), 16'd1);
    check("lit_old_shadow", 16'(nibble), 16'h0);
    step(9);                                   // e=31
    check("lit_no_ack_yet", 16'({upd_ack, busy}), 16'b01);
    step(1);                                   // e=32, boundary passed
    check("lit_ack", 16'({upd_ack, busy}), 16'b10);
    check("lit_nib_idx0", 16'(nibble), 16'h4);
    step(4);                                   // e=36
    check("lit_nib_idx1", 16'(nibble), 16'h3);

    step(11);                                  // e=47, request on boundary edge
    digit_data = 16'h0042; upd_req = 1'b1;
    step(1);                                   // e=48
    upd_req = 1'b0;
    check("lit_bnd_ack", 16'({upd_ack, busy}), 16'b10);
    check("lit_bnd_nib", 16'(nibble), 16'h2);
    step(4);                                   // e=52 idx1
    check("lit_lzb_idx1", 16'({nibble, 3'b000, blank}), 16'({4'h4, 4'h0}));
    step(4);                                   // e=56 idx2
    check("lit_lzb_idx2", 16'(blank), 16'(LZB));

    step(2);                                   // e=58, cnt=2
    en = 1'b0;
    step(3);
    digit_data = 16'h5678; upd_req = 1'b1;
    step(1);
    upd_req = 1'b0;
    check("lit_busy_en0", 16'(busy), 16'd1);
    step(6);
    check("lit_frozen", 16'({a1, a0, nibble}), 16'({2'd2, 4'h0}));
    en = 1'b1;
    step(2);                                   // e=60
    check("lit_resume", 16'({a1, a0, tick}), 16'({2'd3, 1'b1}));
    step(4);                                   // e=64
    check("lit_ack2", 16'({upd_ack, frame_done, nibble}), 16'({1'b1, 1'b1, 4'h8}));

    step(1);
    digit_data = 16'h9ABC; upd_req = 1'b1;
    step(1);
    upd_req = 1'b0;
    step(2);
    check("lit_busy_prerst", 16'(busy), 16'd1);
    rst = 1'b1;
    step(1);
    check("lit_rst_mid", 16'({a1, a0, nibble, tick, frame_done, upd_ack, busy, blank}), 16'h0);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (upd_ack) acks++;
    end
    check("lit_no_ack_after_rst", 16'(acks), 16'd0);

    digit_data = 16'h0007; upd_req = 1'b1;
    step(1);
    upd_req = 1'b0;
    step(1);
    upd_req = 1'b1;
    step(1);
    upd_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (upd_ack) acks++;
    end
    check("lit_single_ack", 16'(acks), 16'd1);
    step(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
